// File: rtl/multi_matmul_ctrl.sv
// Tile scheduler: walks one multi_matmul array over every (row, col-group) output tile.
// Per tile: 1 clear cycle + K_STEPS feed cycles + >=2 wait cycles + >=1 output cycle.
// Backpressure: holds the finished tile on out_valid, issuing no new reads, until out_ready.
module multi_matmul_ctrl #(
    parameter int INNER_DIMENSION = 64,
    parameter int BLOCK_SIZE      = 2,
    parameter int ROW_TILES       = 4,
    parameter int COL_TILES       = 8,
    parameter int TOTAL_MODULES   = 2,
    parameter int ADDR_W          = 16,
    localparam int K_STEPS  = INNER_DIMENSION / BLOCK_SIZE,
    localparam int COL_GRPS = COL_TILES / TOTAL_MODULES,
    localparam int ROW_W    = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1,
    localparam int GRP_W    = (COL_GRPS > 1) ? $clog2(COL_GRPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic              n_rd_en,
    output logic [ADDR_W-1:0] n_addr,
    output logic              mm_en,
    output logic              mm_reset_acc,
    input  logic              mm_acc_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_row,
    output logic [GRP_W-1:0]  out_grp,
    output logic              out_last
);

    localparam int K_W = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_TILES - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(COL_GRPS - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(K_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             mm_en_q, mm_en_d;

    logic             rd_en;
    logic             tile_last;
    logic [31:0]      w_addr_full;
    logic [31:0]      n_addr_full;

    // The tile currently held in the array is the last of the pass.
    assign tile_last = (row_q == ROW_LAST) && (grp_q == GRP_LAST);

    // Next-state, counter advance and strobe outputs; abort overrides everything at the end.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        grp_d        = grp_q;
        k_d          = k_q;
        rd_en        = 1'b0;
        mm_reset_acc = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    row_d   = '0;
                    grp_d   = '0;
                    k_d     = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mm_reset_acc = 1'b1;
                k_d          = '0;
                state_d      = S_FEED;
            end
            S_FEED: begin
                rd_en = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_WAIT: begin
                // acc_done only counts once the read pipe has drained, so a stale
                // or early level cannot cut off the last operand step
                if (!mm_en_q && mm_acc_done) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (tile_last) begin
                        state_d = S_DONE;
                    end else begin
                        if (grp_q == GRP_LAST) begin
                            grp_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            grp_d = grp_q + GRP_W'(1);
                        end
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abandon the pass: no reads, no tile offered, no completion pulse
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            row_d     = row_q;
            grp_d     = grp_q;
            k_d       = k_q;
            rd_en     = 1'b0;
            out_valid = 1'b0;
            done      = 1'b0;
        end
    end

    // The array enable trails the buffer read by the one-cycle buffer latency.
    always_comb begin
        mm_en_d = rd_en;
    end

    // Operand addresses at full width, truncated to the buffer address width.
    always_comb begin
        w_addr_full = 32'(row_q) * 32'(K_STEPS) + 32'(k_q);
        n_addr_full = 32'(grp_q) * 32'(K_STEPS) + 32'(k_q);
    end

    // Output drive: addresses and tile tags read as zero whenever they are not qualified.
    always_comb begin
        busy     = (state_q != S_IDLE);
        w_rd_en  = rd_en;
        n_rd_en  = rd_en;
        w_addr   = rd_en ? ADDR_W'(w_addr_full) : '0;
        n_addr   = rd_en ? ADDR_W'(n_addr_full) : '0;
        mm_en    = mm_en_q;
        out_row  = (state_q == S_OUT) ? row_q : '0;
        out_grp  = (state_q == S_OUT) ? grp_q : '0;
        out_last = (state_q == S_OUT) && tile_last;
    end

    // State, tile counters and the enable pipe; synchronous reset returns to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            grp_q   <= '0;
            k_q     <= '0;
            mm_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            grp_q   <= grp_d;
            k_q     <= k_d;
            mm_en_q <= mm_en_d;
        end
    end

endmodule

// File: tb/tb_multi_matmul_ctrl.sv
// Self-checking bench for multi_matmul_ctrl with a tile/position level reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// The acc_done stub rises 2 cycles after the last mm_en, or is held high in early mode.
module tb_multi_matmul_ctrl;

    localparam int K     = 4;
    localparam int CG    = 2;
    localparam int TILES = 4;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort, mm_acc_done, out_ready;
    logic          busy, done, w_rd_en, n_rd_en, mm_en, mm_reset_acc, out_valid, out_last;
    logic [AW-1:0] w_addr, n_addr;
    logic [0:0]    out_row, out_grp;

    always #5 clk = ~clk;

    multi_matmul_ctrl #(
        .INNER_DIMENSION(8), .BLOCK_SIZE(2), .ROW_TILES(2),
        .COL_TILES(4), .TOTAL_MODULES(2), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .n_rd_en(n_rd_en), .n_addr(n_addr),
        .mm_en(mm_en), .mm_reset_acc(mm_reset_acc), .mm_acc_done(mm_acc_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_grp(out_grp), .out_last(out_last)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit chk_en = 0, early = 0, seen = 0;
    int since = 1000;

    // reference model: pass active, tile index, position in tile (0 clear, 1..K feed, >K wait)
    bit m_active = 0, m_out = 0, m_done = 0, m_mmen = 0;
    int m_tile = 0, m_pos = 0;

    // per-pass observation logs
    int hs_row[$], hs_grp[$], wq[$], nq[$];
    int done_cnt, done_cyc, first_out, mmen_cnt, start_cyc;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        hs_row.delete(); hs_grp.delete(); wq.delete(); nq.delete();
        done_cnt = 0; done_cyc = -1; first_out = -1; mmen_cnt = 0;
    endtask

    task automatic step(input bit s, input bit a, input bit r, input bit rdy);
        bit e_rd, accept;
        int e_row, e_grp;
        @(posedge clk); #1;
        if (mm_reset_acc) seen = 0;
        if (mm_en) begin seen = 1; since = 0; end
        else if (since < 1000) since++;
        mm_acc_done = early ? 1'b1 : (seen && since >= 2);
        start = s; abort = a; rst = r; out_ready = rdy;
        @(negedge clk);
        e_row = m_tile / CG;
        e_grp = m_tile % CG;
        e_rd  = m_active && !m_out && !m_done && m_pos >= 1 && m_pos <= K && !a;
        if (chk_en) begin
            chk("busy", busy, m_active);
            chk("done", done, m_done && !a);
            chk("w_rd_en", w_rd_en, e_rd);
            chk("n_rd_en", n_rd_en, e_rd);
            chk("w_addr", w_addr, e_rd ? e_row * K + m_pos - 1 : 0);
            chk("n_addr", n_addr, e_rd ? e_grp * K + m_pos - 1 : 0);
            chk("mm_en", mm_en, m_mmen);
            chk("mm_reset_acc", mm_reset_acc, m_active && !m_out && !m_done && m_pos == 0);
            chk("out_valid", out_valid, m_out && !a);
            chk("out_row", out_row, m_out ? e_row : 0);
            chk("out_grp", out_grp, m_out ? e_grp : 0);
            chk("out_last", out_last, m_out && m_tile == TILES - 1);
        end
        if (out_valid && out_ready) begin hs_row.push_back(out_row); hs_grp.push_back(out_grp); end
        if (done) begin done_cnt++; done_cyc = cyc - start_cyc; end
        if (out_valid && first_out < 0) first_out = cyc - start_cyc;
        if (mm_en) mmen_cnt++;
        if (w_rd_en) wq.push_back(w_addr);
        if (n_rd_en) nq.push_back(n_addr);
        // advance the model by one cycle
        if (r) begin
            m_active = 0; m_out = 0; m_done = 0; m_mmen = 0; m_tile = 0; m_pos = 0;
            chk_en = 1;
        end else begin
            accept = !m_mmen && mm_acc_done;
            if (!m_active) begin
                if (s && !a) begin
                    m_active = 1; m_tile = 0; m_pos = 0; m_out = 0; m_done = 0;
                end
            end else if (a) begin
                m_active = 0; m_out = 0; m_done = 0;
            end else if (m_done) begin
                m_active = 0; m_done = 0;
            end else if (m_out) begin
                if (rdy) begin
                    m_out = 0;
                    if (m_tile == TILES - 1) m_done = 1;
                    else begin m_tile++; m_pos = 0; end
                end
            end else if (m_pos > K && accept) begin
                m_out = 1;
            end else if (m_pos < 100) begin
                m_pos++;
            end
            m_mmen = e_rd;
        end
        cyc++;
    endtask

    // mode 0 plain, 1 backpressure on tile 1, 2 plain (early set by caller), 3 start during OUT
    task automatic run_pass(input int mode);
        int hold = 0, n = 0;
        bit rdy, s;
        clear_logs();
        start_cyc = cyc;
        step(1, 0, 0, 1);
        while (m_active && n < 400) begin
            rdy = 1; s = 0;
            if (mode == 1 && m_out && m_tile == 1 && hold < 5) begin rdy = 0; hold++; end
            if (mode == 3 && m_out) s = 1;
            step(s, 0, 0, rdy);
            n++;
        end
        chk("pass_terminates", m_active, 0);
    endtask

    task automatic check_pass(input string nm, input int exp_done, input int exp_first);
        int exp_row[4] = '{0, 0, 1, 1};
        int exp_grp[4] = '{0, 1, 0, 1};
        int exp_w[16]  = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};
        int exp_n[16]  = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
        chk({nm, "_tiles"}, hs_row.size(), 4);
        for (int i = 0; i < 4 && i < hs_row.size(); i++) begin
            chk({nm, "_tile_row"}, hs_row[i], exp_row[i]);
            chk({nm, "_tile_grp"}, hs_grp[i], exp_grp[i]);
        end
        chk({nm, "_w_count"}, wq.size(), 16);
        for (int i = 0; i < 16 && i < wq.size(); i++) chk({nm, "_w_seq"}, wq[i], exp_w[i]);
        chk({nm, "_n_count"}, nq.size(), 16);
        for (int i = 0; i < 16 && i < nq.size(); i++) chk({nm, "_n_seq"}, nq[i], exp_n[i]);
        chk({nm, "_done_pulses"}, done_cnt, 1);
        chk({nm, "_done_cycle"}, done_cyc, exp_done);
        chk({nm, "_first_out_cycle"}, first_out, exp_first);
        chk({nm, "_mm_en_cycles"}, mmen_cnt, 16);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_w_rd_en"}, w_rd_en, 0);
        chk({nm, "_n_rd_en"}, n_rd_en, 0);
        chk({nm, "_w_addr"}, w_addr, 0);
        chk({nm, "_n_addr"}, n_addr, 0);
        chk({nm, "_mm_en"}, mm_en, 0);
        chk({nm, "_mm_reset_acc"}, mm_reset_acc, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_out_row"}, out_row, 0);
        chk({nm, "_out_grp"}, out_grp, 0);
        chk({nm, "_out_last"}, out_last, 0);
    endtask

    initial begin
        int n;
        rst = 1; start = 0; abort = 0; out_ready = 0; mm_acc_done = 0;

        // reset
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk_all_zero("reset");

        // plain pass, acc_done 2 cycles after last mm_en: OUT at 9, done at 37
        run_pass(0);
        check_pass("basic", 37, 9);

        // 5 stalled cycles on tile 1 push completion out by 5
        run_pass(1);
        check_pass("backpressure", 42, 9);

        // acc_done held high: WAIT still waits for the pipe, 8 cycles per tile
        early = 1;
        run_pass(2);
        check_pass("early_acc", 33, 8);
        early = 0;

        // start pulses during OUT are ignored
        run_pass(3);
        check_pass("start_busy", 37, 9);

        // abort at k=2 of tile 2
        clear_logs();
        start_cyc = cyc;
        step(1, 0, 0, 1);
        n = 0;
        while (!(m_active && !m_out && m_tile == 2 && m_pos == 3) && n < 200) begin
            step(0, 0, 0, 1);
            n++;
        end
        chk("abort_reach_point", m_tile * 10 + m_pos, 23);
        step(0, 1, 0, 1);
        chk("abort_cycle_rd_en", w_rd_en, 0);
        chk("abort_cycle_done", done, 0);
        step(0, 0, 0, 1);
        chk("abort_busy", busy, 0);
        chk("abort_mm_en", mm_en, 0);
        chk("abort_no_done", done_cnt, 0);
        run_pass(0);
        check_pass("after_abort", 37, 9);

        // rst while waiting on tile 1
        start_cyc = cyc;
        step(1, 0, 0, 1);
        n = 0;
        while (!(m_active && !m_out && m_tile == 1 && m_pos == K + 2) && n < 200) begin
            step(0, 0, 0, 1);
            n++;
        end
        chk("rst_reach_wait", m_tile * 10 + m_pos, 16);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        chk_all_zero("rst_in_wait");
        run_pass(0);
        check_pass("after_rst", 37, 9);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) early = ($urandom_range(0, 1) == 1);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 399) == 0, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_matmul_ctrl.md
# multi_matmul_ctrl

Tile scheduler that sequences one `multi_matmul` array through a full output matrix. It holds ROW_TILES × (COL_TILES/TOTAL_MODULES) output tiles and, for each tile, performs four steps in order:
- clear the accumulators;
- stream INNER_DIMENSION/BLOCK_SIZE operand steps from the W and N operand buffers;
- wait for the array's accumulate-done;
- hand the finished tile to the downstream writer over a valid/ready handshake.

It sits between the operand buffers, `multi_matmul`, and the output writer in the Multi-Head Attention datapath.

## Interface
Parameters:
- INNER_DIMENSION, 64, shared inner dimension; must be a multiple of BLOCK_SIZE
- BLOCK_SIZE, 2, inner elements consumed per `multi_matmul` enable cycle
- ROW_TILES, 4, output row-tiles (W side)
- COL_TILES, 8, output column-tiles (N side); must be a multiple of TOTAL_MODULES
- TOTAL_MODULES, 2, column tiles computed in parallel per pass
- ADDR_W, 16, operand-buffer address width
- Derived: K_STEPS = INNER_DIMENSION/BLOCK_SIZE; COL_GRPS = COL_TILES/TOTAL_MODULES; ROW_W = max(1, clog2(ROW_TILES)); GRP_W = max(1, clog2(COL_GRPS))

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a full matrix pass; sampled only in IDLE
- abort  in  1  abandon the current pass; return to IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last tile handshakes
- w_rd_en / w_addr  out  1 / ADDR_W  W buffer read; address = row·K_STEPS + k
- n_rd_en / n_addr  out  1 / ADDR_W  N buffer read; address = grp·K_STEPS + k
- mm_en  out  1  drives `multi_matmul` en; equals rd_en delayed one cycle (buffer read latency 1)
- mm_reset_acc  out  1  drives `multi_matmul` reset_acc
- mm_acc_done  in  1  from `multi_matmul` acc_done_modules
- out_valid  out  1  finished tile is ready on `multi_matmul` outputs
- out_ready  in  1  writer accepts the tile
- out_row  out  ROW_W  row index of the presented tile
- out_grp  out  GRP_W  column-group index of the presented tile
- out_last  out  1  presented tile is the final one of the pass

## Operation
- States: IDLE, CLEAR, FEED, WAIT, OUT, DONE.
- IDLE
  - start=1 → clear row/grp/k → CLEAR.
- CLEAR (one cycle)
  - mm_reset_acc=1; k=0 → FEED.
- FEED (exactly K_STEPS cycles)
  - w_rd_en = n_rd_en = 1; k increments each cycle.
  - When k = K_STEPS−1 → WAIT.
- WAIT
  - rd_en=0.
  - mm_acc_done is accepted only when mm_en=0, i.e. after the pipeline has drained.
  - Accepted mm_acc_done → OUT.
- OUT
  - out_valid=1; out_row, out_grp and out_last are held stable until out_valid·out_ready.
  - On handshake with out_last=0: grp increments; when grp wraps from COL_GRPS−1 to 0, row increments. Then → CLEAR.
  - On handshake with out_last=1 → DONE.
- DONE (one cycle)
  - done=1 → IDLE.
- out_last = (row = ROW_TILES−1) && (grp = COL_GRPS−1).
- start outside IDLE is ignored.
- abort in any non-IDLE state:
  - next state is IDLE;
  - rd_en, out_valid and done drop that cycle, and the mm_en pipe is flushed to 0;
  - no done pulse is produced.
- abort and start in the same cycle in IDLE: abort wins; the controller stays in IDLE.
- rst overrides abort.
- Addresses are computed at full width and truncated to ADDR_W. Configuring so that no truncation occurs is the integrator's responsibility.

## Timing
- Reset: state=IDLE and counters=0. Every output is 0: busy, done, w_rd_en, n_rd_en, w_addr, n_addr, mm_en, mm_reset_acc, out_valid, out_row, out_grp, out_last.
- start sampled at cycle 0:
  - CLEAR in cycle 1;
  - FEED in cycles 2..K_STEPS+1;
  - mm_en high in cycles 3..K_STEPS+2;
  - WAIT from cycle K_STEPS+2.
- If mm_acc_done is already high when mm_en falls, OUT is entered at cycle K_STEPS+4.
- Back-to-back tiles: the cycle after the OUT handshake is CLEAR. Per-tile overhead is therefore 1 (CLEAR) + ≥2 (WAIT) + ≥1 (OUT) cycles.
- busy rises the cycle after start and falls the cycle after DONE.

## Test plan
All scenarios use INNER_DIMENSION=8, BLOCK_SIZE=2 (K_STEPS=4), ROW_TILES=2, COL_TILES=4, TOTAL_MODULES=2 (COL_GRPS=2), with an acc_done model that rises 2 cycles after the last mm_en.

- Basic pass: start, out_ready tied 1.
  - Expect 4 tiles in order (row,grp) = (0,0),(0,1),(1,0),(1,1).
  - w_addr sequences are 0–3, 0–3, 4–7, 4–7; n_addr sequences are 0–3, 4–7, 0–3, 4–7.
  - out_last only on the 4th tile, followed by exactly one done pulse.
- Backpressure: hold out_ready=0 for 5 cycles on tile 1.
  - out_valid, out_row and out_grp stay stable.
  - No rd_en or mm_reset_acc until the handshake.
- Early acc_done: hold mm_acc_done=1 throughout.
  - WAIT still lasts until mm_en=0; mm_en is high exactly 4 cycles per tile.
- Abort mid-FEED at k=2 of tile 2.
  - The next cycle shows IDLE, busy=0, mm_en=0, no done.
  - A subsequent start restarts at (0,0).
- start while busy, pulsed during OUT: ignored; tile count remains 4.
- rst asserted in WAIT: all outputs are 0 in the next cycle; start afterwards produces a full, correct pass.
